// File: rtl/uart_tx_framer.sv
// uart_tx_framer: UART transmit framer. Serialises one character per frame as
// start bit (0), DATA_BITS data bits LSB first, an optional parity bit and
// STOP_BITS stop bits (1). Every bit lasts CLOCK_FREQ/BAUD_RATE clocks.
//
// Build option: define UART_TX_FIFO_EN to put a FIFO_DEPTH-entry character FIFO
// in front of the framer. Without it the block holds one character and
// accepts only in IDLE or on the last cycle of the final stop bit.
//
// Ports:
//   clk           rising-edge clock
//   reset_n       synchronous active-low reset
//   data_in       character to send (bits above DATA_BITS-1 ignored)
//   data_in_valid producer offers data_in
//   data_in_ready block accepts data_in this cycle
//   serial_out    UART line, idle high, registered
//   busy          a frame is on the line
//   frame_done    one-cycle pulse on the last cycle of the final stop bit
module uart_tx_framer #(
  parameter int CLOCK_FREQ = 125_000_000,
  parameter int BAUD_RATE  = 115_200,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 8
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] data_in,
  input  logic       data_in_valid,
  output logic       data_in_ready,
  output logic       serial_out,
  output logic       busy,
  output logic       frame_done
);

  localparam int BIT_CYCLES = CLOCK_FREQ / BAUD_RATE;
  localparam int CW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam logic [CW-1:0] BIT_LAST = CW'(BIT_CYCLES - 1);
  localparam logic [7:0] MASK = 8'hFF >> (8 - DATA_BITS);

  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

  state_t          state, state_n;
  logic [CW-1:0]   cnt, cnt_n;
  logic [2:0]      bit_idx, bit_idx_n;
  logic            stop_idx, stop_idx_n;
  logic [7:0]      shreg, shreg_n;
  logic            par_bit, par_bit_n;
  logic            line_n;
  logic            rdy_en;   // holds ready low until the first cycle after reset
  logic            bit_end, stop_last, push, pending, take;
  logic [7:0]      src;

  assign bit_end    = (cnt == BIT_LAST);
  assign stop_last  = (state == STOP) && bit_end && (stop_idx == 1'(STOP_BITS - 1));
  assign frame_done = stop_last;
  assign busy       = (state != IDLE);
  assign push       = data_in_valid & data_in_ready;
  // A new frame starts from IDLE or directly out of the last stop cycle.
  assign take       = pending & ((state == IDLE) | stop_last);

`ifdef UART_TX_FIFO_EN
  localparam int AW = $clog2(FIFO_DEPTH);

  logic [7:0]  mem [FIFO_DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [AW:0] count;
  logic        empty, full, bypass, wr, rd;

  assign empty         = (count == '0);
  assign full          = (count == (AW+1)'(FIFO_DEPTH));
  assign data_in_ready = rdy_en & ~full;
  assign pending       = ~empty | push;
  // An arrival into an empty FIFO while the framer can start goes straight
  // to the shift register so the start bit follows on the next cycle.
  assign bypass        = take & empty;
  assign wr            = push & ~bypass;
  assign rd            = take & ~empty;
  assign src           = empty ? data_in : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr) wr_ptr <= wr_ptr + 1'b1;
      if (rd) rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(wr) - (AW+1)'(rd);
    end
  end

  always_ff @(posedge clk) begin
    if (wr) mem[wr_ptr] <= data_in;
  end
`else
  assign data_in_ready = rdy_en & ((state == IDLE) | stop_last);
  assign pending       = push;
  assign src           = data_in;
`endif

  always_comb begin
    state_n    = state;
    cnt_n      = '0;
    bit_idx_n  = bit_idx;
    stop_idx_n = stop_idx;
    shreg_n    = shreg;
    par_bit_n  = par_bit;
    if (state != IDLE) cnt_n = bit_end ? '0 : cnt + 1'b1;
    case (state)
      IDLE: ;
      START: if (bit_end) begin
        state_n   = DATA;
        bit_idx_n = '0;
      end
      DATA: if (bit_end) begin
        shreg_n = shreg >> 1;
        if (bit_idx == 3'(DATA_BITS - 1)) begin
          state_n    = (PARITY == 0) ? STOP : PAR;
          stop_idx_n = 1'b0;
        end else begin
          bit_idx_n = bit_idx + 1'b1;
        end
      end
      PAR: if (bit_end) begin
        state_n    = STOP;
        stop_idx_n = 1'b0;
      end
      STOP: if (bit_end) begin
        if (stop_idx == 1'(STOP_BITS - 1)) state_n = IDLE;
        else stop_idx_n = stop_idx + 1'b1;
      end
      default: state_n = IDLE;
    endcase
    if (take) begin
      state_n   = START;
      cnt_n     = '0;
      shreg_n   = src & MASK;
      par_bit_n = (^(src & MASK)) ^ (PARITY == 1);
    end
    // Line value for the next cycle, so serial_out is a plain flop.
    case (state_n)
      START:   line_n = 1'b0;
      DATA:    line_n = shreg_n[0];
      PAR:     line_n = par_bit_n;
      default: line_n = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= IDLE;
      cnt        <= '0;
      bit_idx    <= '0;
      stop_idx   <= 1'b0;
      shreg      <= '0;
      par_bit    <= 1'b0;
      serial_out <= 1'b1;
      rdy_en     <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      bit_idx    <= bit_idx_n;
      stop_idx   <= stop_idx_n;
      shreg      <= shreg_n;
      par_bit    <= par_bit_n;
      serial_out <= line_n;
      rdy_en     <= 1'b1;
    end
  end

endmodule

// File: tb/tb_uart_tx_framer.sv
// Bench for uart_tx_framer: four instances (8N1, 8E1, 8O1, 7N2) at
// BIT_CYCLES=10, directed plus randomised frames against a bit-list model.
module tb_uart_tx_framer;
  localparam int CF = 1_000_000;
  localparam int BR = 100_000;
  localparam int BC = 10;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [7:0] data_in;
  logic [3:0] valid;
  wire  [3:0] rdy, so, bz, fd;

  int passed = 0;
  int total  = 0;
  int fails  = 0;

  int db[4]    = '{8, 8, 8, 7};
  int pm[4]    = '{0, 2, 1, 0};
  int sbits[4] = '{1, 1, 1, 2};

  always #5 clk = ~clk;

  uart_tx_framer #(.CLOCK_FREQ(CF), .BAUD_RATE(BR), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) u0 (
    .clk(clk), .reset_n(reset_n), .data_in(data_in), .data_in_valid(valid[0]), .data_in_ready(rdy[0]),
    .serial_out(so[0]), .busy(bz[0]), .frame_done(fd[0]));
  uart_tx_framer #(.CLOCK_FREQ(CF), .BAUD_RATE(BR), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(4)) u1 (
    .clk(clk), .reset_n(reset_n), .data_in(data_in), .data_in_valid(valid[1]), .data_in_ready(rdy[1]),
    .serial_out(so[1]), .busy(bz[1]), .frame_done(fd[1]));
  uart_tx_framer #(.CLOCK_FREQ(CF), .BAUD_RATE(BR), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(4)) u2 (
    .clk(clk), .reset_n(reset_n), .data_in(data_in), .data_in_valid(valid[2]), .data_in_ready(rdy[2]),
    .serial_out(so[2]), .busy(bz[2]), .frame_done(fd[2]));
  uart_tx_framer #(.CLOCK_FREQ(CF), .BAUD_RATE(BR), .DATA_BITS(7), .PARITY(0), .STOP_BITS(2), .FIFO_DEPTH(4)) u3 (
    .clk(clk), .reset_n(reset_n), .data_in(data_in), .data_in_valid(valid[3]), .data_in_ready(rdy[3]),
    .serial_out(so[3]), .busy(bz[3]), .frame_done(fd[3]));

  task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] want);
    total++;
    assert (got === want) passed++;
    else begin
      fails++;
      $error("FAIL %s got=%0h want=%0h", tag, got, want);
    end
  endtask

  function automatic int flen(input int i);
    return BC * (1 + db[i] + ((pm[i] != 0) ? 1 : 0) + sbits[i]);
  endfunction

  // Expected line, one entry per clock: frame bit list stretched to BC cycles.
  function automatic logic [127:0] fexp(input int i, input logic [7:0] b);
    logic q[$];
    logic p;
    logic [127:0] r;
    p = 1'b0;
    r = '0;
    q.push_back(1'b0);
    for (int k = 0; k < db[i]; k++) begin
      q.push_back(b[k]);
      p = p ^ b[k];
    end
    if (pm[i] == 2) q.push_back(p);
    if (pm[i] == 1) q.push_back(~p);
    for (int k = 0; k < sbits[i]; k++) q.push_back(1'b1);
    for (int c = 0; c < q.size() * BC; c++) r[c] = q[c / BC];
    return r;
  endfunction

  // Caller has valid[i]=1, data_in=b set at a sample point; the next edge accepts.
  task automatic run_frame(input int i, input logic [7:0] b, input bit chain, input logic [7:0] nb,
                           input int mut_at, input int poke_at);
    logic [127:0] obs, ob, of, one;
    int L;
    L   = flen(i);
    one = 128'd1;
    obs = '0; ob = '0; of = '0;
    chk($sformatf("ready_before_accept_u%0d", i), rdy[i], 1'b1);
    @(posedge clk); #1;
    valid[i] = 1'b0;
    for (int c = 0; c < L; c++) begin
      if (c > 0) begin @(posedge clk); #1; end
      if (c == mut_at) data_in = 8'h00;
      if (c == poke_at) begin valid[i] = 1'b1; data_in = 8'h33; end
      else if (c == poke_at + 1) valid[i] = 1'b0;
      obs[c] = so[i];
      ob[c]  = bz[i];
      of[c]  = fd[i];
      if (chain && c == L - 1) begin
        chk($sformatf("handoff_ready_u%0d", i), rdy[i], 1'b1);
        valid[i] = 1'b1;
        data_in  = nb;
      end
    end
    chk($sformatf("line_u%0d_%02h", i, b), obs, fexp(i, b));
    chk($sformatf("busy_u%0d_%02h", i, b), ob, (one << L) - one);
    chk($sformatf("frame_done_u%0d_%02h", i, b), of, one << (L - 1));
  endtask

  task automatic idle_chk(input int i, input int n, input string tag);
    logic bad;
    bad = 1'b0;
    for (int c = 0; c < n; c++) begin
      @(posedge clk); #1;
      if (so[i] !== 1'b1 || bz[i] !== 1'b0 || fd[i] !== 1'b0) bad = 1'b1;
    end
    chk(tag, bad, 1'b0);
  endtask

  initial begin
    logic [7:0] b, nb;
    int i, n;
    logic sawfd;
`ifdef UART_TX_FIFO_EN
    logic [511:0] fobs, fexpv;
    logic [127:0] tmp;
    int acc, fdn;
    logic rp, rdy_after, seen;
`endif
    reset_n = 1'b0;
    valid   = '0;
    data_in = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_line", so, 4'hF);
    chk("reset_busy", bz, 4'h0);
    chk("reset_done", fd, 4'h0);
    chk("reset_ready", rdy, 4'h0);
    reset_n = 1'b1;
    @(posedge clk); #1;
    chk("ready_after_reset", rdy, 4'hF);

    // 8N1 0x55, 8E1/8O1 0x07, 7N2 0xFF
    valid[0] = 1'b1; data_in = 8'h55; run_frame(0, 8'h55, 0, 8'h00, -1, -1);
    idle_chk(0, 12, "idle_after_55");
    valid[1] = 1'b1; data_in = 8'h07; run_frame(1, 8'h07, 0, 8'h00, -1, -1);
    valid[2] = 1'b1; data_in = 8'h07; run_frame(2, 8'h07, 0, 8'h00, -1, -1);
    valid[3] = 1'b1; data_in = 8'hFF; run_frame(3, 8'hFF, 0, 8'h00, -1, -1);
    idle_chk(3, 12, "idle_after_7n2");

    // data_in changes mid-frame; in single-character mode a mid-frame offer is dropped
    valid[0] = 1'b1; data_in = 8'hA5;
`ifdef UART_TX_FIFO_EN
    run_frame(0, 8'hA5, 0, 8'h00, 15, -1);
`else
    run_frame(0, 8'hA5, 0, 8'h00, 15, 40);
    idle_chk(0, 30, "midframe_offer_ignored");
`endif

    // back-to-back handoff, zero gap
    valid[0] = 1'b1; data_in = 8'h12;
    run_frame(0, 8'h12, 1, 8'h34, -1, -1);
    run_frame(0, 8'h34, 0, 8'h00, -1, -1);
    idle_chk(0, 5, "idle_after_chain");

`ifdef UART_TX_FIFO_EN
    fobs = '0; fexpv = '0; acc = 0; fdn = 0; seen = 1'b0; rdy_after = 1'b1;
    valid[0] = 1'b1; data_in = 8'h41; rp = rdy[0];
    for (int c = 0; c < 500; c++) begin
      @(posedge clk); #1;
      if (valid[0] && rp) acc++;
      if (acc < 5) data_in = 8'(8'h41 + acc);
      else valid[0] = 1'b0;
      if (acc == 5 && !seen) begin rdy_after = rdy[0]; seen = 1'b1; end
      rp = rdy[0];
      fobs[c] = so[0];
      fdn += int'(fd[0]);
    end
    for (int f = 0; f < 5; f++) begin
      tmp = fexp(0, 8'(8'h41 + f));
      fexpv[f*100 +: 100] = tmp[99:0];
    end
    chk("fifo_accepted", 32'(acc), 32'd5);
    chk("fifo_ready_full", rdy_after, 1'b0);
    chk("fifo_line", fobs, fexpv);
    chk("fifo_done_count", 32'(fdn), 32'd5);
    idle_chk(0, 10, "fifo_idle_after");
`endif

    // reset at cycle 35 of a frame, with extra offers that a FIFO would hold
    valid[0] = 1'b1; data_in = 8'h3C;
    @(posedge clk); #1;
    valid[0] = 1'b0;
    sawfd = fd[0];
    for (int c = 1; c <= 35; c++) begin
      @(posedge clk); #1;
      if (c == 5 || c == 6) begin valid[0] = 1'b1; data_in = 8'(8'h50 + c); end
      else valid[0] = 1'b0;
      sawfd = sawfd | fd[0];
    end
    reset_n = 1'b0;
    @(posedge clk); #1;
    chk("midreset_line", so[0], 1'b1);
    chk("midreset_busy", bz[0], 1'b0);
    chk("midreset_done", fd[0], 1'b0);
    chk("midreset_ready", rdy[0], 1'b0);
    chk("midreset_no_pulse", sawfd, 1'b0);
    reset_n = 1'b1;
    @(posedge clk); #1;
    chk("midreset_ready_back", rdy[0], 1'b1);
    idle_chk(0, 150, "midreset_pending_discarded");

    // randomised bursts on random instances
    for (int it = 0; it < 8; it++) begin
      i = $urandom_range(0, 3);
      n = $urandom_range(1, 3);
      b = 8'($urandom);
      valid[i] = 1'b1; data_in = b;
      for (int f = 0; f < n; f++) begin
        nb = 8'($urandom);
        run_frame(i, b, (f < n - 1), nb, -1, -1);
        b = nb;
      end
      idle_chk(i, 8, $sformatf("rand_idle_%0d", it));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
